pipeline_ctrl: RTL and testbench

- Consumes hazard requests and turns them into per-stage register enables and bubble/flush strobes for the five-stage core.
- Inputs are:
  - the load-use stall request from the stall unit,
  - the EX-stage taken-branch signal,
  - the data-memory request/acknowledge handshake.
- Tracks multi-cycle data-memory waits with a state machine and watchdog. A stuck memory raises a sticky error.
- Sits between the hazard logic and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_wdog.sv | 38 +++
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared FSM state encodings and sizing helper for the
//               five-stage core pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_ERROR    = 2'b10
    } pipe_state_t;

    // Width of a counter that must hold 0..timeout_cycles without wrapping.
    function automatic int wait_cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_wdog.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_wdog
// Description : Data-memory watchdog. Counts consecutive busy cycles and
//               flags the busy cycle on which the limit has been reached.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_wdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    output logic timeout_o
);

    localparam int                c_cnt_w = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

    logic [c_cnt_w-1:0] r_wait_cnt;

    // Counter holds at the limit so it can never wrap back to a safe value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (!busy_i) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_limit) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end

    assign timeout_o = busy_i & (r_wait_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Turns hazard requests into pipeline register enables and
//               bubble/flush strobes; tracks data-memory waits with a
//               watchdog. Optional performance counters: PIPE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_flush_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] load_use_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o
);

    pipe_state_t r_state;
    logic        r_mem_timeout;

    logic w_mem_busy;
    logic w_frozen;
    logic w_busy_row;
    logic w_branch_row;
    logic w_stall_row;
    logic w_run_row;
    logic w_wdog_busy;
    logic w_wdog_expire;

    assign w_mem_busy = dmem_req_i & ~dmem_ack_i;
    assign w_frozen   = rst_i | (r_state == S_ERROR);

    // Mutually exclusive priority rows; exactly one is high each cycle
    // unless the pipeline is frozen.
    assign w_busy_row   = ~w_frozen & w_mem_busy;
    assign w_branch_row = ~w_frozen & ~w_mem_busy & branch_taken_i;
    assign w_stall_row  = ~w_frozen & ~w_mem_busy & ~branch_taken_i & stall_i;
    assign w_run_row    = ~w_frozen & ~w_mem_busy & ~branch_taken_i & ~stall_i;

    assign pc_en_o        = w_branch_row | w_run_row;
    assign if_id_en_o     = w_branch_row | w_run_row;
    assign id_ex_en_o     = w_branch_row | w_stall_row | w_run_row;
    assign ex_mem_en_o    = w_branch_row | w_stall_row | w_run_row;
    assign if_id_flush_o  = w_branch_row;
    assign id_ex_flush_o  = w_branch_row | w_stall_row;
    assign mem_wb_flush_o = w_busy_row;

    assign w_wdog_busy = w_mem_busy & (r_state != S_ERROR);

    pipeline_ctrl_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .busy_i    (w_wdog_busy),
        .timeout_o (w_wdog_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_RUN;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_busy) begin
                        r_state <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    // Ack or a dropped request both end the wait; a drop is
                    // an aborted access, not a fault.
                    if (dmem_ack_i || !dmem_req_i) begin
                        r_state <= S_RUN;
                    end else if (w_wdog_expire) begin
                        r_state       <= S_ERROR;
                        r_mem_timeout <= 1'b1;
                    end
                end
                S_ERROR: begin
                    r_state <= S_ERROR;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign mem_timeout_o = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_load_use_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_mem_wait_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_load_use_cnt <= '0;
            r_flush_cnt    <= '0;
            r_mem_wait_cnt <= '0;
        end else begin
            if (w_stall_row && (r_load_use_cnt != '1)) begin
                r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
            end
            if (w_branch_row && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_wdog_busy && (r_mem_wait_cnt != '1)) begin
                r_mem_wait_cnt <= r_mem_wait_cnt + CNT_W'(1);
            end
        end
    end

    assign load_use_cnt_o = r_load_use_cnt;
    assign flush_cnt_o    = r_flush_cnt;
    assign mem_wait_cnt_o = r_mem_wait_cnt;
`else
    assign load_use_cnt_o = '0;
    assign flush_cnt_o    = '0;
    assign mem_wait_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int T     = 4;
    localparam int CNT_W = 6;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             stall_i = 1'b0;
    logic             branch_taken_i = 1'b0;
    logic             dmem_req_i = 1'b0;
    logic             dmem_ack_i = 1'b0;
    logic             pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
    logic             if_id_flush_o, id_ex_flush_o, mem_wb_flush_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] load_use_cnt_o, flush_cnt_o, mem_wait_cnt_o;

    int vectors = 0;
    int errors  = 0;

    pipeline_ctrl #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .pc_en_o        (pc_en_o),
        .if_id_en_o     (if_id_en_o),
        .id_ex_en_o     (id_ex_en_o),
        .ex_mem_en_o    (ex_mem_en_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .mem_wb_flush_o (mem_wb_flush_o),
        .mem_timeout_o  (mem_timeout_o),
        .load_use_cnt_o (load_use_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .mem_wait_cnt_o (mem_wait_cnt_o)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem enables, if_id flush, id_ex flush, mem_wb flush}
    logic [6:0] dut_ctrl;
    assign dut_ctrl = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
                       if_id_flush_o, id_ex_flush_o, mem_wb_flush_o};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: error flag, consecutive busy-cycle run, raw event counts.
    bit m_err;
    int m_run, m_lu, m_fl, m_mw;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_err <= 1'b0;
            m_run <= 0;
            m_lu  <= 0;
            m_fl  <= 0;
            m_mw  <= 0;
        end else if (!m_err) begin
            if (dmem_req_i && !dmem_ack_i) begin
                m_mw  <= m_mw + 1;
                m_run <= m_run + 1;
                if (m_run + 1 > T) m_err <= 1'b1;
            end else begin
                m_run <= 0;
                if (branch_taken_i)  m_fl <= m_fl + 1;
                else if (stall_i)    m_lu <= m_lu + 1;
            end
        end
    end

    function automatic logic [63:0] cnt_exp(input int n);
        int mx;
        mx = (1 << CNT_W) - 1;
        if (!PERF) return 64'd0;
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    function automatic logic [6:0] ctrl_exp();
        if (rst_i || m_err)                  return 7'b0000_000;
        else if (dmem_req_i && !dmem_ack_i)  return 7'b0000_001;
        else if (branch_taken_i)             return 7'b1111_110;
        else if (stall_i)                    return 7'b0011_010;
        else                                 return 7'b1111_000;
    endfunction

    always @(negedge clk) begin : p_compare
        check("ctrl",         64'(dut_ctrl),       64'(ctrl_exp()));
        check("mem_timeout",  64'(mem_timeout_o),  64'(m_err));
        check("load_use_cnt", 64'(load_use_cnt_o), cnt_exp(m_lu));
        check("flush_cnt",    64'(flush_cnt_o),    cnt_exp(m_fl));
        check("mem_wait_cnt", 64'(mem_wait_cnt_o), cnt_exp(m_mw));
    end

    // Apply one cycle of inputs just after the edge, return mid-cycle.
    task automatic cyc(input logic r, input logic s, input logic b, input logic q, input logic a);
        @(posedge clk);
        #1;
        rst_i          = r;
        stall_i        = s;
        branch_taken_i = b;
        dmem_req_i     = q;
        dmem_ack_i     = a;
        @(negedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        check("reset_ctrl", 64'(dut_ctrl), 64'b0);
        check("reset_timeout", 64'(mem_timeout_o), 64'd0);
        cyc(1, 0, 0, 0, 0);

        cyc(0, 0, 0, 0, 0);
        check("idle_ctrl", 64'(dut_ctrl), 64'b1111000);

        cyc(0, 1, 0, 0, 0);
        check("load_use_ctrl", 64'(dut_ctrl), 64'b0011010);
        cyc(0, 0, 0, 0, 0);
        check("load_use_cnt1", 64'(load_use_cnt_o), PERF ? 64'd1 : 64'd0);

        cyc(0, 1, 1, 0, 0);
        check("branch_stall_ctrl", 64'(dut_ctrl), 64'b1111110);
        cyc(0, 0, 0, 0, 0);
        check("flush_cnt1", 64'(flush_cnt_o), PERF ? 64'd1 : 64'd0);

        for (int i = 0; i < 3; i++) begin
            cyc(0, i[0], 1'b0, 1, 0);
            check("mem_wait_freeze", 64'(dut_ctrl), 64'b0000001);
        end
        cyc(0, 0, 0, 1, 1);
        check("mem_ack_release", 64'(dut_ctrl), 64'b1111000);
        check("mem_wait_cnt3", 64'(mem_wait_cnt_o), PERF ? 64'd3 : 64'd0);

        cyc(0, 0, 0, 1, 1);
        check("zero_wait_ctrl", 64'(dut_ctrl), 64'b1111000);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("abort_ctrl", 64'(dut_ctrl), 64'b1111000);
        check("abort_no_error", 64'(mem_timeout_o), 64'd0);

        for (int i = 0; i < T + 1; i++) cyc(0, 0, 0, 1, 0);
        check("timeout_not_yet", 64'(mem_timeout_o), 64'd0);
        cyc(0, 0, 0, 1, 0);
        check("timeout_set", 64'(mem_timeout_o), 64'd1);
        check("timeout_frozen", 64'(dut_ctrl), 64'b0);
        cyc(0, 1, 1, 0, 0);
        check("timeout_sticky", 64'(mem_timeout_o), 64'd1);
        check("timeout_still_frozen", 64'(dut_ctrl), 64'b0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("timeout_cleared", 64'(mem_timeout_o), 64'd0);
        check("after_reset_ctrl", 64'(dut_ctrl), 64'b1111000);

        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        rst_i = 1'b1;
        #1;
        check("midwait_rst_ctrl", 64'(dut_ctrl), 64'b0);
        check("midwait_rst_wait_cnt", 64'(mem_wait_cnt_o), 64'd0);
        check("midwait_rst_timeout", 64'(mem_timeout_o), 64'd0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("midwait_release_ctrl", 64'(dut_ctrl), 64'b1111000);

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 150) == 0,
                ($urandom % 3) == 0,
                ($urandom % 5) == 0,
                ($urandom % 4) != 0,
                ($urandom % 3) == 0);
        end
        cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
